batch_index_sequencer: RTL and testbench
========================================

# batch_index_sequencer

Sequential driver for the first-set-bit extractor. It accepts 64-bit request bitmaps (batches) from the upstream scheduler over a valid/ready handshake and holds the pending bitmap in a register. It emits one set-bit index per cycle, lowest bit first, over a valid/ready handshake to the downstream consumer, clearing each bit as it is issued. It requests a new batch only when the pending bitmap is exhausted.

## Interface
- SIZE, 64, bitmap width
- log_SIZE, 6, index width; SIZE == 2**log_SIZE
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous clear of pending batch and output stage
- batch_in  in  SIZE  request bitmap; bit i set = index i pending
- batch_valid  in  1  batch_in valid
- batch_ready  out  1  block can accept a batch this cycle
- idx_out  out  log_SIZE  issued index
- idx_valid  out  1  idx_out valid
- idx_ready  in  1  downstream accepts idx_out this cycle
- idx_last  out  1  idx_out is the final set bit of its batch
- drop_cnt  out  16  count of accepted all-zero batches, wraps

## Operation
- Registers:
  - pend[SIZE-1:0], the remaining bitmap.
  - Output stage: idx_out, idx_valid, idx_last.
  - state: IDLE or DRAIN.
  - drop_cnt.
- Reset (rst_n=0 at an edge) sets pend=0, state=IDLE, idx_out=0, idx_valid=0, idx_last=0 and drop_cnt=0. While rst_n=0, batch_ready=0.
- batch_ready = rst_n && !flush && (state==IDLE).
- IDLE (pend==0):
  - On batch_valid && batch_ready with batch_in!=0: pend<=batch_in and state<=DRAIN.
  - On batch_valid && batch_ready with batch_in==0: the batch is consumed and discarded. drop_cnt<=drop_cnt+1, wrapping from 0xFFFF to 0. State stays IDLE and no index is issued.
- DRAIN (pend!=0):
  - Output stage is free when !idx_valid || idx_ready.
  - When the stage is free, load idx_out<=lowest set bit of pend. Bit 0 has the highest priority.
  - In the same load: idx_valid<=1; pend<=pend with that bit cleared; idx_last<=(cleared pend==0).
  - If the cleared pend==0, state<=IDLE.
- Output stage release: if idx_ready && idx_valid and no new load occurs, idx_valid<=0. idx_out and idx_last hold their last values.
- Output hold rule: idx_out and idx_last are stable while idx_valid && !idx_ready.
- flush=1 at an edge:
  - pend<=0, state<=IDLE, idx_valid<=0, idx_last<=0.
  - Overrides any load or accept in that cycle. Any batch presented with flush=1 is not accepted (batch_ready=0).
  - drop_cnt is unaffected.
- rst_n has priority over flush.
- Index order within a batch is strictly ascending. Each set bit is issued exactly once. Bits are never reordered across batches.

## Timing
- Batch accepted at edge A: pend loaded at A.
  - First idx_valid=1 after edge A+1, provided the output stage is free.
  - Latency from the acceptance edge to first index: 1 cycle.
- With idx_ready held at 1, one index is issued per cycle. A batch with k set bits issues its indices after edges A+1 … A+k.
- The last index of a batch is loaded at edge L. State is IDLE after L, so batch_ready=1 in cycle L+1.
  - The next batch is accepted at the earliest at edge L+1, and its first index loads at L+2.
  - Result: one bubble cycle between batches.
- Backpressure: if idx_ready=0, pend does not advance and idx_out holds.
- Boundaries:
  - Single-bit batch: one index with idx_last=1.
  - Bit SIZE-1 alone: idx_out=63 with idx_last=1.
  - All-ones batch: 64 indices, 0 through 63; idx_last is set only on index 63.
  - Reset asserted mid-batch: all state is cleared at that edge and the remaining bits are lost.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with batch_valid=1 -> batch_ready=0, idx_valid=0, idx_out=0, drop_cnt=0 throughout. The cycle after release, batch_ready=1.
- Batch 0x8000_0000_0000_0025 with idx_ready=1 -> idx_out is 0, 2, 5, 63 on 4 consecutive cycles starting 1 cycle after the accept edge. idx_last=1 only on 63. batch_ready=1 in the cycle after 63 loads.
- Batch 0x3, idx_ready=0 for 3 cycles after idx_valid rises -> idx_out=0 is held stable with idx_valid=1. After idx_ready=1: idx_out=0, then 1 (idx_last=1), then idx_valid=0.
- Batch 0x0 accepted -> drop_cnt increments 0 to 1 and no idx_valid. Preloading via 65535 zero batches then one more -> drop_cnt wraps to 0.
- Batch 0xF0: after index 4 issues, assert flush for 1 cycle together with batch_valid and batch 0x1 -> idx_valid=0 next cycle, 0x1 is not accepted, and batch_ready=1 the following cycle.
- Back-to-back batches 0x1 then 0x2 with batch_valid held -> idx 0 (idx_last=1), one idle cycle, then idx 1 (idx_last=1).

Source files
------------

// File: rtl/batch_index_sequencer_if.sv
// Handshake bundle for the batch index sequencer: batch input from the scheduler,
// index output to the consumer.
interface batch_index_sequencer_if #(
  parameter int unsigned SIZE     = 64,
  parameter int unsigned LOG_SIZE = 6
);
  logic [SIZE-1:0]     batch_in;
  logic                batch_valid;
  logic                batch_ready;
  logic [LOG_SIZE-1:0] idx_out;
  logic                idx_valid;
  logic                idx_ready;
  logic                idx_last;

  // Scheduler/consumer side drives batches and index backpressure.
  modport master (
    output batch_in, batch_valid, idx_ready,
    input  batch_ready, idx_out, idx_valid, idx_last
  );

  // Sequencer side.
  modport slave (
    input  batch_in, batch_valid, idx_ready,
    output batch_ready, idx_out, idx_valid, idx_last
  );
endinterface

// File: rtl/batch_index_sequencer.sv
// Accepts a request bitmap, then issues its set-bit indices one per cycle, lowest
// first, through a single registered output stage. Zero bitmaps are counted and dropped.
module batch_index_sequencer #(
  parameter int unsigned SIZE     = 64,
  parameter int unsigned LOG_SIZE = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  batch_index_sequencer_if.slave   bus,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SIZE-1:0]     pend_q, pend_d;
  logic [LOG_SIZE-1:0] idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic                accept_c;
  logic                stage_free_c;
  logic                load_c;
  logic [LOG_SIZE-1:0] low_idx_c;
  logic [SIZE-1:0]     pend_clr_c;

  assign bus.batch_ready = rst_n && !flush && (state_q == S_IDLE);
  assign accept_c        = bus.batch_valid && bus.batch_ready;
  assign stage_free_c    = !valid_q || bus.idx_ready;
  assign load_c          = (state_q == S_DRAIN) && stage_free_c;

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    low_idx_c = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        low_idx_c = LOG_SIZE'(i);
      end
    end
  end

  assign pend_clr_c = pend_q & (pend_q - SIZE'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c && (bus.batch_in != '0)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (stage_free_c && (pend_clr_c == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
    end
  end

  // Datapath next values: pending bitmap, output stage and drop counter.
  always_comb begin
    pend_d  = pend_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    drop_d  = drop_q;

    if ((state_q == S_IDLE) && accept_c) begin
      if (bus.batch_in != '0) begin
        pend_d = bus.batch_in;
      end else begin
        drop_d = drop_q + CNT_W'(1);
      end
    end

    if (load_c) begin
      idx_d   = low_idx_c;
      valid_d = 1'b1;
      pend_d  = pend_clr_c;
      last_d  = (pend_clr_c == '0);
    end else if (valid_q && bus.idx_ready) begin
      valid_d = 1'b0;
    end

    // Flush kills the batch and the output stage but keeps idx_out and the count.
    if (flush) begin
      pend_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.idx_out   = idx_q;
  assign bus.idx_valid = valid_q;
  assign bus.idx_last  = last_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_batch_index_sequencer.sv
// Scoreboard bench: accepted batches are expanded into ascending index lists;
// a negedge monitor pops and compares every index transfer and tracks the drop count.
`timescale 1ns/1ps
module tb_batch_index_sequencer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] drop_cnt;

  batch_index_sequencer_if #(.SIZE(64), .LOG_SIZE(6)) bus ();

  batch_index_sequencer #(.SIZE(64), .LOG_SIZE(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  typedef struct packed {
    logic [5:0] idx;
    logic       last;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] model_drop;
  int          total;
  int          bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: indices of the set bits in ascending order, last flag on the highest.
  function automatic void push_batch(input logic [63:0] b);
    int hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < 64; i++) if (b[i]) hi = i;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) begin
        e.idx  = 6'(i);
        e.last = (i == hi);
        sb_q.push_back(e);
      end
    end
  endfunction

  // Monitor: inputs settle 1ns after posedge, so negedge sees the next edge's handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      model_drop = '0;
    end else begin
      chk("drop_cnt", 64'(drop_cnt), 64'(model_drop));
      if (flush) begin
        sb_q.delete();
      end else begin
        if (bus.idx_valid && bus.idx_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_idx actual=%0d required=none @%0t", bus.idx_out, $time);
          end else begin
            e = sb_q.pop_front();
            chk("idx_out", 64'(bus.idx_out), 64'(e.idx));
            chk("idx_last", 64'(bus.idx_last), 64'(e.last));
          end
        end
        if (bus.batch_valid && bus.batch_ready) begin
          if (bus.batch_in == '0) model_drop = model_drop + 16'd1;
          else push_batch(bus.batch_in);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_batch();
    logic [63:0] b;
    case ($urandom_range(0, 5))
      0: b = '0;
      1: b = 64'(1) << $urandom_range(0, 63);
      2: b = '1;
      3: b = {$urandom, $urandom};
      4: b = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      default: b = {$urandom, $urandom} & 64'hF000_0000_0000_000F;
    endcase
    return b;
  endfunction

  initial begin
    #950000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  exp_a [4];
    logic [63:0] b;
    int          budget;
    logic        acc;

    total = 0;
    bad = 0;
    model_drop = '0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.batch_in = 64'h5;
    bus.batch_valid = 1'b1;
    bus.idx_ready = 1'b1;

    // Reset held for two cycles with a batch offered.
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_batch_ready", 64'(bus.batch_ready), 64'(0));
      chk("rst_idx_valid", 64'(bus.idx_valid), 64'(0));
      chk("rst_idx_out", 64'(bus.idx_out), 64'(0));
      chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    end
    rst_n = 1'b1;
    bus.batch_valid = 1'b0;
    cycle();
    chk("post_rst_batch_ready", 64'(bus.batch_ready), 64'(1));

    // Sparse batch with top bit, full throughput.
    exp_a[0] = 6'd0; exp_a[1] = 6'd2; exp_a[2] = 6'd5; exp_a[3] = 6'd63;
    bus.batch_in = 64'h8000_0000_0000_0025;
    bus.batch_valid = 1'b1;
    cycle();
    bus.batch_valid = 1'b0;
    chk("t2_busy_ready", 64'(bus.batch_ready), 64'(0));
    chk("t2_lat_valid", 64'(bus.idx_valid), 64'(0));
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t2_valid", 64'(bus.idx_valid), 64'(1));
      chk("t2_idx", 64'(bus.idx_out), 64'(exp_a[k]));
      chk("t2_last", 64'(bus.idx_last), 64'(k == 3));
    end
    chk("t2_ready_after_last", 64'(bus.batch_ready), 64'(1));
    cycle();
    chk("t2_release", 64'(bus.idx_valid), 64'(0));

    // Backpressure hold.
    bus.batch_in = 64'h3;
    bus.batch_valid = 1'b1;
    bus.idx_ready = 1'b0;
    cycle();
    bus.batch_valid = 1'b0;
    cycle();
    chk("t3_first_valid", 64'(bus.idx_valid), 64'(1));
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t3_hold_valid", 64'(bus.idx_valid), 64'(1));
      chk("t3_hold_idx", 64'(bus.idx_out), 64'(0));
      chk("t3_hold_last", 64'(bus.idx_last), 64'(0));
    end
    bus.idx_ready = 1'b1;
    cycle();
    chk("t3_idx1", 64'(bus.idx_out), 64'(1));
    chk("t3_last1", 64'(bus.idx_last), 64'(1));
    cycle();
    chk("t3_release", 64'(bus.idx_valid), 64'(0));

    // Zero batches: count, then wrap.
    bus.batch_in = '0;
    bus.batch_valid = 1'b1;
    cycle();
    chk("t4_drop1", 64'(drop_cnt), 64'(1));
    chk("t4_no_idx", 64'(bus.idx_valid), 64'(0));
    for (int k = 0; k < 65534; k++) cycle();
    chk("t4_drop_max", 64'(drop_cnt), 64'(16'hFFFF));
    cycle();
    bus.batch_valid = 1'b0;
    chk("t4_drop_wrap", 64'(drop_cnt), 64'(0));
    chk("t4_no_idx_wrap", 64'(bus.idx_valid), 64'(0));

    // Flush mid-batch with a competing batch offered.
    bus.batch_in = 64'hF0;
    bus.batch_valid = 1'b1;
    cycle();
    bus.batch_valid = 1'b0;
    cycle();
    chk("t5_idx4", 64'(bus.idx_out), 64'(4));
    flush = 1'b1;
    bus.batch_in = 64'h1;
    bus.batch_valid = 1'b1;
    #1;
    chk("t5_flush_ready", 64'(bus.batch_ready), 64'(0));
    cycle();
    chk("t5_flush_valid", 64'(bus.idx_valid), 64'(0));
    chk("t5_flush_last", 64'(bus.idx_last), 64'(0));
    flush = 1'b0;
    bus.batch_valid = 1'b0;
    #1;
    chk("t5_ready_after", 64'(bus.batch_ready), 64'(1));
    cycle();
    chk("t5_not_accepted", 64'(bus.idx_valid), 64'(0));

    // Back-to-back single-bit batches: one bubble between them.
    bus.batch_in = 64'h1;
    bus.batch_valid = 1'b1;
    cycle();
    bus.batch_in = 64'h2;
    cycle();
    chk("t6_idx0", 64'(bus.idx_out), 64'(0));
    chk("t6_last0", 64'(bus.idx_last), 64'(1));
    chk("t6_valid0", 64'(bus.idx_valid), 64'(1));
    cycle();
    bus.batch_valid = 1'b0;
    chk("t6_bubble", 64'(bus.idx_valid), 64'(0));
    cycle();
    chk("t6_idx1", 64'(bus.idx_out), 64'(1));
    chk("t6_last1", 64'(bus.idx_last), 64'(1));
    chk("t6_valid1", 64'(bus.idx_valid), 64'(1));
    cycle();

    // Reset in the middle of a batch loses the remaining bits.
    bus.batch_in = 64'hFF;
    bus.batch_valid = 1'b1;
    cycle();
    bus.batch_valid = 1'b0;
    cycle();
    cycle();
    chk("t7_idx1", 64'(bus.idx_out), 64'(1));
    rst_n = 1'b0;
    cycle();
    chk("t7_rst_valid", 64'(bus.idx_valid), 64'(0));
    chk("t7_rst_ready", 64'(bus.batch_ready), 64'(0));
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("t7_nothing_left", 64'(bus.idx_valid), 64'(0));
    chk("t7_drop_zero", 64'(drop_cnt), 64'(0));

    // Randomized batches with random backpressure.
    for (int n = 0; n < 120; n++) begin
      b = rand_batch();
      bus.batch_in = b;
      bus.batch_valid = 1'b1;
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 300) begin
        bus.idx_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = bus.batch_ready;
        cycle();
        budget++;
      end
      if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
      bus.batch_valid = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        bus.idx_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
    end

    bus.idx_ready = 1'b1;
    budget = 0;
    while (sb_q.size() != 0 && budget < 200) begin
      cycle();
      budget++;
    end
    chk("drain_left", 64'(sb_q.size()), 64'(0));
    cycle();
    cycle();
    chk("final_idle", 64'(bus.idx_valid), 64'(0));
    chk("final_ready", 64'(bus.batch_ready), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
